// File: rtl/dec_seq_pkg.sv
// Shared types and constants for the dec configuration sequencer.
// State codes are visible to the host through STATUS[2:0].
package dec_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETDIV = 3'd2,
    ST_RUNON  = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_STOP   = 3'd5
  } dec_seq_state_t;

  localparam logic [2:0] REG_PERIOD0 = 3'd0;
  localparam logic [2:0] REG_PERIOD1 = 3'd1;
  localparam logic [2:0] REG_PERIOD2 = 3'd2;
  localparam logic [2:0] REG_PERIOD3 = 3'd3;
  localparam logic [2:0] REG_DIV     = 3'd4;
  localparam logic [2:0] REG_CMD     = 3'd5;
  localparam logic [2:0] REG_STATUS  = 3'd6;
  localparam logic [2:0] REG_TIMEOUT = 3'd7;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_STOP_BIT  = 1;

  localparam logic DEC_RUN = 1'b0;
  localparam logic DEC_DIV = 1'b1;

  function automatic logic is_busy(input dec_seq_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/dec_seq_if.sv
// Host register port plus the write ports into dec; slave is the sequencer side.
// Single-cycle strobes, no backpressure in either direction.
interface dec_seq_if;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wrdata;
  logic [31:0] cfg_rddata;
  logic        dec_ctl_wr;
  logic        dec_ctl_addr;
  logic [31:0] dec_ctl_wrdata;
  logic        dec_ram_wr;
  logic [1:0]  dec_ram_addr;
  logic [31:0] dec_ram_wrdata;
  logic        busy;
  logic        timeout_irq;

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wrdata,
    output cfg_rddata, dec_ctl_wr, dec_ctl_addr, dec_ctl_wrdata,
    output dec_ram_wr, dec_ram_addr, dec_ram_wrdata, busy, timeout_irq
  );

  modport master (
    output cfg_wr, cfg_addr, cfg_wrdata,
    input  cfg_rddata, dec_ctl_wr, dec_ctl_addr, dec_ctl_wrdata,
    input  dec_ram_wr, dec_ram_addr, dec_ram_wrdata, busy, timeout_irq
  );
endinterface

// File: rtl/dec_seq_timer.sv
// Run timer: clears, counts while enabled, flags the last cycle before TIMEOUT.
// Terminal output is combinational from the count register; no backpressure.
module dec_seq_timer #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [M-1:0] i_timeout,
  output logic         o_terminal
);
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  logic [M-1:0] r_count;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ONE;
    end
  end

  // A zero timeout disables the compare entirely.
  assign o_terminal = (i_timeout != '0) && (r_count == (i_timeout - ONE));
endmodule

// File: rtl/dec_seq.sv
// Replays the host's period/divider profile into dec on start, then supervises the run.
// Start to ACTIVE takes 7 cycles; all dec outputs decode from registered state.
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int M = 32
) (
  input  logic     clk,
  input  logic     clrn,
  dec_seq_if.slave bus
);
  dec_seq_state_t r_state;
  logic [M-1:0]   r_period [4];
  logic [1:0]     r_div;
  logic [M-1:0]   r_timeout;
  logic [1:0]     r_idx;
  logic [7:0]     r_runs;
  logic           r_restart;
  logic           r_irq;

  logic w_cmd, w_start, w_stop, w_go, w_cfg_open, w_terminal;
  logic w_ram_wr, w_ctl_wr;

  assign w_cmd      = bus.cfg_wr && (bus.cfg_addr == REG_CMD);
  assign w_start    = w_cmd && bus.cfg_wrdata[CMD_START_BIT];
  assign w_stop     = w_cmd && bus.cfg_wrdata[CMD_STOP_BIT];
  assign w_go       = w_start && !w_stop;
  assign w_cfg_open = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);

  dec_seq_timer #(.M(M)) u_timer (
    .clk        (clk),
    .clrn       (clrn),
    .i_clr      (r_state == ST_RUNON),
    .i_en       (r_state == ST_ACTIVE),
    .i_timeout  (r_timeout),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= ST_IDLE;
      r_idx     <= 2'd0;
      r_runs    <= 8'd0;
      r_restart <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      r_idx <= 2'd0;
      case (r_state)
        ST_IDLE: if (w_go) r_state <= ST_LOAD;
        ST_LOAD: begin
          if (w_stop) begin
            r_state   <= ST_STOP;
            r_restart <= 1'b0;
          end else begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_state <= ST_SETDIV;
          end
        end
        ST_SETDIV: begin
          r_state <= w_stop ? ST_STOP : ST_RUNON;
          if (w_stop) r_restart <= 1'b0;
        end
        ST_RUNON: begin
          r_state <= w_stop ? ST_STOP : ST_ACTIVE;
          if (w_stop) r_restart <= 1'b0;
        end
        ST_ACTIVE: begin
          if (w_terminal || w_start || w_stop) begin
            r_state   <= ST_STOP;
            r_restart <= w_go;
            r_irq     <= w_terminal;
          end
        end
        ST_STOP: begin
          r_runs    <= r_runs + 8'd1;
          r_restart <= 1'b0;
          r_state   <= r_restart ? ST_LOAD : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Profile registers are frozen while the sequence is being replayed into dec.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 4; i++) r_period[i] <= '0;
      r_div     <= 2'd0;
      r_timeout <= '0;
    end else if (bus.cfg_wr && w_cfg_open) begin
      case (bus.cfg_addr)
        REG_PERIOD0, REG_PERIOD1, REG_PERIOD2, REG_PERIOD3:
          r_period[bus.cfg_addr[1:0]] <= M'(bus.cfg_wrdata);
        REG_DIV:     r_div     <= bus.cfg_wrdata[1:0];
        REG_TIMEOUT: r_timeout <= M'(bus.cfg_wrdata);
        default: ;
      endcase
    end
  end

  assign w_ram_wr = (r_state == ST_LOAD);
  assign w_ctl_wr = (r_state == ST_SETDIV) || (r_state == ST_RUNON) || (r_state == ST_STOP);

  assign bus.dec_ram_wr     = w_ram_wr;
  assign bus.dec_ram_addr   = w_ram_wr ? r_idx : 2'd0;
  assign bus.dec_ram_wrdata = w_ram_wr ? 32'(r_period[r_idx]) : 32'd0;
  assign bus.dec_ctl_wr     = w_ctl_wr;
  assign bus.dec_ctl_addr   = (r_state == ST_SETDIV) ? DEC_DIV : DEC_RUN;
  assign bus.busy           = is_busy(r_state);
  assign bus.timeout_irq    = r_irq;

  always_comb begin
    bus.dec_ctl_wrdata = 32'd0;
    case (r_state)
      ST_SETDIV: bus.dec_ctl_wrdata = {30'd0, r_div};
      ST_RUNON:  bus.dec_ctl_wrdata = 32'd1;
      default:   bus.dec_ctl_wrdata = 32'd0;
    endcase
  end

  always_comb begin
    bus.cfg_rddata = 32'd0;
    case (bus.cfg_addr)
      REG_PERIOD0, REG_PERIOD1, REG_PERIOD2, REG_PERIOD3:
        bus.cfg_rddata = 32'(r_period[bus.cfg_addr[1:0]]);
      REG_DIV:     bus.cfg_rddata = {30'd0, r_div};
      REG_STATUS:  bus.cfg_rddata = {16'd0, r_runs, 4'd0, is_busy(r_state), r_state};
      REG_TIMEOUT: bus.cfg_rddata = 32'(r_timeout);
      default:     bus.cfg_rddata = 32'd0;
    endcase
  end
endmodule

// File: tb/tb_dec_seq.sv
// Bench for dec_seq: directed scenarios pin exact cycles, then random host traffic
// is checked every cycle against a schedule-queue model of the expected dec writes.
module tb_dec_seq;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  dec_seq_if bus();
  dec_seq #(.M(32)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: the queue holds the per-cycle write schedule still owed to dec
  // (code 1 = ram write idx, 2 = divider, 3 = run on, 5 = run off).
  typedef struct {int code; int idx; bit restart;} ent_t;
  ent_t        m_q[$];
  bit          m_active;
  logic [31:0] m_cnt, m_to;
  logic [31:0] m_per [4];
  logic [1:0]  m_div;
  logic [7:0]  m_runs;
  bit          m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_code();
    if (m_q.size() > 0) return m_q[0].code;
    return m_active ? 4 : 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    int c = m_code();
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return m_per[a[1:0]];
      3'd4: return {30'd0, m_div};
      3'd6: return {16'd0, m_runs, 4'd0, (c != 0), 3'(c)};
      3'd7: return m_to;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_cnt = 0;
    m_to = 0;
    for (int i = 0; i < 4; i++) m_per[i] = 0;
    m_div = 0;
    m_runs = 0;
    m_irq = 1'b0;
  endtask

  task automatic push_load();
    for (int i = 0; i < 4; i++) m_q.push_back('{code: 1, idx: i, restart: 1'b0});
    m_q.push_back('{code: 2, idx: 0, restart: 1'b0});
    m_q.push_back('{code: 3, idx: 0, restart: 1'b0});
  endtask

  task automatic model_step(input logic wr, input logic [2:0] a, input logic [31:0] d);
    int   c;
    bit   st, sp, term, open;
    ent_t e;
    c    = m_code();
    st   = wr && (a == 3'd5) && d[0];
    sp   = wr && (a == 3'd5) && d[1];
    term = (m_to != 0) && (m_cnt == m_to - 32'd1);
    open = (c == 0) || (c == 4);
    m_irq = 1'b0;
    case (c)
      0: if (st && !sp) push_load();
      1, 2, 3: begin
        if (sp) begin
          m_q.delete();
          m_q.push_back('{code: 5, idx: 0, restart: 1'b0});
        end else begin
          e = m_q.pop_front();
          if (m_q.size() == 0) begin
            m_active = 1'b1;
            m_cnt = 0;
          end
        end
      end
      4: begin
        if (term || st || sp) begin
          m_active = 1'b0;
          m_q.push_back('{code: 5, idx: 0, restart: st && !sp});
          m_irq = term;
        end else begin
          m_cnt = m_cnt + 32'd1;
        end
      end
      5: begin
        e = m_q.pop_front();
        m_runs = m_runs + 8'd1;
        if (e.restart) push_load();
      end
      default: ;
    endcase
    if (wr && open) begin
      if (a <= 3'd3) m_per[a[1:0]] = d;
      else if (a == 3'd4) m_div = d[1:0];
      else if (a == 3'd7) m_to = d;
    end
  endtask

  task automatic tick(input logic wr, input logic [2:0] a, input logic [31:0] d);
    bus.cfg_wr = wr;
    bus.cfg_addr = a;
    bus.cfg_wrdata = d;
    @(posedge clk);
    model_step(wr, a, d);
    #1;
    bus.cfg_wr = 1'b0;
  endtask

  int          cc;
  int          ci;
  logic [31:0] exp_ram_d, exp_ctl_d;
  always @(negedge clk) begin
    if (chk_en && clrn) begin
      cc = m_code();
      ci = (m_q.size() > 0) ? m_q[0].idx : 0;
      exp_ram_d = (cc == 1) ? m_per[ci] : 32'd0;
      exp_ctl_d = (cc == 2) ? {30'd0, m_div} : (cc == 3) ? 32'd1 : 32'd0;
      chk("ram_wr", 32'(bus.dec_ram_wr), 32'(cc == 1));
      if (cc == 1) chk("ram_addr", 32'(bus.dec_ram_addr), ci);
      chk("ram_wrdata", bus.dec_ram_wrdata, exp_ram_d);
      chk("ctl_wr", 32'(bus.dec_ctl_wr), 32'(cc == 2 || cc == 3 || cc == 5));
      if (cc == 2 || cc == 3 || cc == 5) chk("ctl_addr", 32'(bus.dec_ctl_addr), 32'(cc == 2));
      chk("ctl_wrdata", bus.dec_ctl_wrdata, exp_ctl_d);
      chk("busy", 32'(bus.busy), 32'(cc != 0));
      chk("timeout_irq", 32'(bus.timeout_irq), 32'(m_irq));
      chk("cfg_rddata", bus.cfg_rddata, m_read(bus.cfg_addr));
      chk("strobe_overlap", 32'(bus.dec_ram_wr && bus.dec_ctl_wr), 32'd0);
    end
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] exp_p [4];
  int          k;
  logic [2:0]  ra;
  logic [31:0] rd;
  int          r;

  initial begin
    exp_p[0] = 32'd5; exp_p[1] = 32'd3; exp_p[2] = 32'd2; exp_p[3] = 32'd7;
    bus.cfg_wr = 1'b0;
    bus.cfg_addr = 3'd6;
    bus.cfg_wrdata = 32'd0;
    model_reset();
    #13;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ram_wr", 32'(bus.dec_ram_wr), 0);
    chk("rst_ctl_wr", 32'(bus.dec_ctl_wr), 0);
    chk("rst_irq", 32'(bus.timeout_irq), 0);
    chk("rst_status", bus.cfg_rddata, 0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    chk_en = 1'b1;

    // Load profile {5,3,2,7}, DIV=2, TIMEOUT=10, then start.
    tick(1, 3'd0, 5); tick(1, 3'd1, 3); tick(1, 3'd2, 2); tick(1, 3'd3, 7);
    tick(1, 3'd4, 2); tick(1, 3'd7, 10); tick(1, 3'd5, 1);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("load_ram_wr", 32'(bus.dec_ram_wr), 1);
      chk("load_ram_addr", 32'(bus.dec_ram_addr), i);
      chk("load_ram_data", bus.dec_ram_wrdata, exp_p[i]);
      chk("load_busy", 32'(bus.busy), 1);
      tick(0, 3'd6, 0);
    end
    settle();
    chk("setdiv_ctl", {bus.dec_ctl_wr, 15'd0, 15'(bus.dec_ctl_addr), bus.dec_ctl_wrdata[0]}, {1'b1, 15'd0, 15'd1, 1'b0});
    chk("setdiv_data", bus.dec_ctl_wrdata, 2);
    tick(0, 3'd6, 0);
    settle();
    chk("runon_addr", 32'(bus.dec_ctl_addr), 0);
    chk("runon_data", bus.dec_ctl_wrdata, 1);
    tick(0, 3'd6, 0);
    k = 7;
    settle();
    while (!bus.dec_ctl_wr && k < 60) begin
      tick(0, 3'd6, 0);
      k++;
      settle();
    end
    chk("timeout_stop_cycle", k, 17);
    chk("timeout_irq_pulse", 32'(bus.timeout_irq), 1);
    chk("timeout_stop_data", bus.dec_ctl_wrdata, 0);
    tick(0, 3'd6, 0);
    settle();
    chk("timeout_irq_once", 32'(bus.timeout_irq), 0);
    chk("status_after_timeout", bus.cfg_rddata, 32'h100);

    // Stop written during the second RAM write.
    tick(1, 3'd5, 1);
    tick(0, 3'd6, 0);
    settle();
    chk("stopload_addr1", 32'(bus.dec_ram_addr), 1);
    tick(1, 3'd5, 2);
    settle();
    chk("stopload_no_ram", 32'(bus.dec_ram_wr), 0);
    chk("stopload_ctl", {31'd0, bus.dec_ctl_wr}, 1);
    chk("cmd_reads_zero", bus.cfg_rddata, 0);
    tick(0, 3'd6, 0);
    settle();
    chk("stopload_idle", bus.cfg_rddata, 32'h200);

    // Restart from ACTIVE with no timeout.
    tick(1, 3'd7, 0);
    tick(1, 3'd5, 1);
    repeat (6) tick(0, 3'd6, 0);
    settle();
    chk("active_status", bus.cfg_rddata, 32'h20C);
    tick(1, 3'd5, 1);
    settle();
    chk("restart_stop", {bus.dec_ctl_wr, bus.dec_ctl_wrdata[30:0]}, 32'h8000_0000);
    tick(0, 3'd6, 0);
    settle();
    chk("restart_reload", {bus.dec_ram_wr, 29'd0, bus.dec_ram_addr}, 32'h8000_0000);
    chk("restart_reload_data", bus.dec_ram_wrdata, 5);
    chk("restart_status", bus.cfg_rddata, 32'h309);
    tick(1, 3'd5, 2);
    tick(0, 3'd6, 0);
    settle();
    chk("restart_idle", bus.cfg_rddata, 32'h400);

    // Write protection in SETDIV, then start+stop together in IDLE.
    tick(1, 3'd5, 1);
    repeat (4) tick(0, 3'd6, 0);
    settle();
    chk("setdiv_status", bus.cfg_rddata, 32'h40A);
    tick(1, 3'd0, 99);
    tick(0, 3'd0, 0);
    settle();
    chk("period0_protected", bus.cfg_rddata, 5);
    tick(1, 3'd5, 2);
    tick(0, 3'd6, 0);
    tick(1, 3'd5, 3);
    tick(0, 3'd6, 0);
    settle();
    chk("startstop_idle", bus.cfg_rddata, 32'h500);

    // Reset while in RUNON.
    tick(1, 3'd5, 1);
    repeat (5) tick(0, 3'd6, 0);
    settle();
    chk("pre_reset_runon", bus.dec_ctl_wrdata, 1);
    chk_en = 1'b0;
    clrn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_ctl_wr", 32'(bus.dec_ctl_wr), 0);
    chk("mid_rst_ctl_data", bus.dec_ctl_wrdata, 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_status", bus.cfg_rddata, 0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    for (int a = 0; a < 8; a++) begin
      bus.cfg_addr = 3'(a);
      #1;
      chk("reg_after_reset", bus.cfg_rddata, 0);
    end
    chk_en = 1'b1;

    // Random host traffic against the model.
    repeat (3000) begin
      r  = $urandom_range(0, 99);
      ra = 3'($urandom_range(0, 7));
      rd = $urandom;
      if (r < 8) begin
        tick(1, 3'd5, 32'($urandom_range(0, 3)));
      end else if (r < 18) begin
        if (ra == 3'd7) rd = 32'($urandom_range(0, 12));
        if (ra == 3'd5) rd = 32'($urandom_range(0, 3));
        tick(1, ra, rd);
      end else begin
        tick(0, ra, rd);
      end
    end
    settle();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
